gray_decode_tracker: RTL and testbench
======================================

Name: gray_decode_tracker

Overview:
- Receive-side counterpart of the binary-to-Gray encoder.
- Samples a Gray-coded position word (e.g. from a Gray counter or rotary/absolute encoder) and decodes it to binary.
- Classifies each new sample as step-up, step-down, hold or illegal jump, and keeps a signed-wrap position accumulator.
- Sits between the Gray source and downstream position/control logic.

Parameters:
- WIDTH, 3, width of Gray input and decoded binary output.
- POS_W, 8, width of the position accumulator (wraps modulo 2^POS_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  gray is sampled on this clock edge.
- gray  input  WIDTH  Gray-coded input word.
- err_clr  input  1  clears fault and forces resync.
- bin  output  WIDTH  decoded binary of last sampled gray.
- bin_valid  output  1  one-cycle pulse: bin updated.
- step_up  output  1  one-cycle pulse: sample = previous + 1 mod 2^WIDTH.
- step_dn  output  1  one-cycle pulse: sample = previous - 1 mod 2^WIDTH.
- err  output  1  one-cycle pulse: illegal transition detected.
- sticky_err  output  1  level, set on err, cleared by err_clr or rst.
- pos  output  POS_W  position accumulator.

Behaviour:
- Reset: rst high asynchronously forces all outputs to 0, state INIT, stored reference to 0.
- Decode rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i from WIDTH-2 down to 0.
- All outputs are registered. Latency is 1 clock from the in_valid edge to bin/bin_valid/step/err.
- FSM states: INIT, TRACK, FAULT.
- INIT:
  - On in_valid: bin <= decode(gray), bin_valid pulse, reference <= decoded value.
  - No step pulse; pos unchanged; go to TRACK.
- TRACK, on in_valid, with d = decoded sample and r = reference:
  - d == r: bin_valid only, no step.
  - d == r+1 mod 2^WIDTH: step_up, pos <= pos+1.
  - d == r-1 mod 2^WIDTH: step_dn, pos <= pos-1.
  - Any other d: err pulse, sticky_err <= 1, pos held, go to FAULT.
  - In every case: bin <= d, bin_valid pulse, reference <= d.
  - Single-bit Gray flips that are not adjacent codes (e.g. 001 -> 101, binary 1 -> 6) are errors.
- FAULT:
  - bin/bin_valid keep updating on in_valid.
  - step_up/step_dn/err suppressed; pos held.
  - Stays in FAULT until err_clr.
- err_clr (any state):
  - sticky_err <= 0, state <= INIT; pos is not cleared.
  - If in_valid is high in the same cycle, err_clr has priority: the sample is ignored, with no bin update and no bin_valid.
- in_valid low: all pulse outputs 0; bin, pos, sticky_err hold.
- pos wraps both ways: max+1 gives 0, 0-1 gives 2^POS_W-1.
- Wrap of the code itself: r=7, d=0 is step_up; r=0, d=7 is step_dn (WIDTH=3).
- Reset mid-operation: immediate clear regardless of clock. First sample after release is treated as INIT (no step).
- Pulses never overlap: at most one of step_up/step_dn/err per cycle.

Test Plan:
- Reset: rst=1 with gray=3'b101, in_valid=1 -> bin=0, pos=0, all pulses/sticky_err 0. Release; first sample 3'b000 -> bin=0, bin_valid=1, no step.
- Up sweep (WIDTH=3) with in_valid every cycle:
  - Stimulus gray 000,001,011,010,110,111,101,100,000.
  - Expect bin 0,1,2,3,4,5,6,7,0, each one cycle after its sample.
  - Expect step_up on the last 8 samples; pos=8.
- Down wrap after reset: gray 000 then 100 then 101 -> bin 7 then 6, two step_dn pulses, pos 255 then 254.
- Hold and gaps: gray 010 twice with in_valid, then in_valid=0 for 3 cycles -> bin_valid twice, no step, all outputs hold.
- Illegal jump, part 1:
  - Gray 001 then 101 -> bin=6, err pulse, sticky_err=1, pos unchanged.
  - Then 111 -> bin=5, bin_valid, no step.
- Illegal jump, part 2 (recovery):
  - err_clr with in_valid high -> sample ignored, sticky_err=0.
  - Next 110 -> bin=4, no step (INIT).
  - Then 111 -> step_up.
- Async reset mid-sweep: assert rst between edges with pos=5 -> pos=0 and sticky_err=0 before the next clock edge.

Source files
------------

// File: rtl/gray_decode_tracker.sv
// Gray-code position receiver: decodes each sampled Gray word to binary, classifies the move
// relative to the previous sample and keeps a wrapping signed position accumulator.
module gray_decode_tracker #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned POS_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] gray,
   input  logic             err_clr,
   output logic [WIDTH-1:0] bin,
   output logic             bin_valid,
   output logic             step_up,
   output logic             step_dn,
   output logic             err,
   output logic             sticky_err,
   output logic [POS_W-1:0] pos
);

   typedef enum logic [1:0] {StInit, StTrack, StFault} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             bin_valid_q, bin_valid_d;
   logic             step_up_q, step_up_d;
   logic             step_dn_q, step_dn_d;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [WIDTH-1:0] dec;
   logic [WIDTH-1:0] ref_inc, ref_dec;

   // Binary bit i is the XOR of all Gray bits at or above i.
   always_comb begin
      dec = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         dec[i] = ^(gray >> i);
      end
   end

   assign ref_inc = ref_q + WIDTH'(1);
   assign ref_dec = ref_q - WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      bin_d       = bin_q;
      bin_valid_d = 1'b0;
      step_up_d   = 1'b0;
      step_dn_d   = 1'b0;
      err_d       = 1'b0;
      sticky_d    = sticky_q;
      pos_d       = pos_q;

      // Clear wins over a coincident sample, which is dropped.
      if (err_clr) begin
         sticky_d = 1'b0;
         state_d  = StInit;
      end else if (in_valid) begin
         bin_d       = dec;
         bin_valid_d = 1'b1;
         ref_d       = dec;
         unique case (state_q)
            StInit: state_d = StTrack;
            StTrack: begin
               if (dec == ref_q) begin
                  state_d = StTrack;
               end else if (dec == ref_inc) begin
                  step_up_d = 1'b1;
                  pos_d     = pos_q + POS_W'(1);
               end else if (dec == ref_dec) begin
                  step_dn_d = 1'b1;
                  pos_d     = pos_q - POS_W'(1);
               end else begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
                  state_d  = StFault;
               end
            end
            StFault: state_d = StFault;
            default: state_d = StInit;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StInit;
         ref_q       <= '0;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         step_up_q   <= 1'b0;
         step_dn_q   <= 1'b0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
         pos_q       <= '0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         bin_q       <= bin_d;
         bin_valid_q <= bin_valid_d;
         step_up_q   <= step_up_d;
         step_dn_q   <= step_dn_d;
         err_q       <= err_d;
         sticky_q    <= sticky_d;
         pos_q       <= pos_d;
      end
   end

   assign bin        = bin_q;
   assign bin_valid  = bin_valid_q;
   assign step_up    = step_up_q;
   assign step_dn    = step_dn_q;
   assign err        = err_q;
   assign sticky_err = sticky_q;
   assign pos        = pos_q;

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Table-driven bench for gray_decode_tracker with a one-deep expected-result scoreboard.
module tb_gray_decode_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] gray = 3'b000;
   logic       err_clr = 1'b0;
   logic [2:0] bin;
   logic       bin_valid, step_up, step_dn, err, sticky_err;
   logic [7:0] pos;

   gray_decode_tracker #(.WIDTH(3), .POS_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .gray       (gray),
      .err_clr    (err_clr),
      .bin        (bin),
      .bin_valid  (bin_valid),
      .step_up    (step_up),
      .step_dn    (step_dn),
      .err        (err),
      .sticky_err (sticky_err),
      .pos        (pos)
   );

   always #5 clk = ~clk;

   // exp packs {bin, bin_valid, step_up, step_dn, err, sticky_err, pos}
   typedef struct {
      logic        rst;
      logic        iv;
      logic        clr;
      logic [2:0]  g;
      logic [15:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [15:0] outs(input logic [2:0] b, input logic bv, input logic u,
                                        input logic d, input logic e, input logic s,
                                        input logic [7:0] p);
      return {b, bv, u, d, e, s, p};
   endfunction

   task automatic addv(input logic r, input logic iv, input logic c, input logic [2:0] g,
                       input logic [2:0] b, input logic bv, input logic u, input logic d,
                       input logic e, input logic s, input logic [7:0] p);
      vec_t v;
      v.rst = r; v.iv = iv; v.clr = c; v.g = g;
      v.exp = outs(b, bv, u, d, e, s, p);
      tbl.push_back(v);
   endtask

   task automatic compare(input string name, input int idx, input logic [15:0] want);
      logic [15:0] got;
      got = outs(bin, bin_valid, step_up, step_dn, err, sticky_err, pos);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s #%0d got bin=%0d bv=%b up=%b dn=%b err=%b sticky=%b pos=%0d | want bin=%0d bv=%b up=%b dn=%b err=%b sticky=%b pos=%0d",
                  name, idx, got[15:13], got[12], got[11], got[10], got[9], got[8], got[7:0],
                  want[15:13], want[12], want[11], want[10], want[9], want[8], want[7:0]);
      end
   endtask

   // Drive on the falling edge, queue the expectation, compare just after the rising edge.
   task automatic apply(input vec_t v, input string name, input int idx);
      @(negedge clk);
      rst = v.rst; in_valid = v.iv; err_clr = v.clr; gray = v.g;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s #%0d scoreboard empty", name, idx);
      end else begin
         compare(name, idx, exp_q.pop_front());
      end
   endtask

   task automatic step(input logic [2:0] g, input logic [2:0] b, input logic bv, input logic u,
                       input logic d, input logic e, input logic s, input logic [7:0] p,
                       input string name, input int idx);
      vec_t v;
      v.rst = 1'b0; v.iv = 1'b1; v.clr = 1'b0; v.g = g;
      v.exp = outs(b, bv, u, d, e, s, p);
      apply(v, name, idx);
   endtask

   initial begin
      // reset with a live sample present
      addv(1, 1, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0);
      addv(1, 1, 0, 3'b101, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0);
      // up sweep
      addv(0, 1, 0, 3'b001, 1, 1, 1, 0, 0, 0, 1);
      addv(0, 1, 0, 3'b011, 2, 1, 1, 0, 0, 0, 2);
      addv(0, 1, 0, 3'b010, 3, 1, 1, 0, 0, 0, 3);
      addv(0, 1, 0, 3'b110, 4, 1, 1, 0, 0, 0, 4);
      addv(0, 1, 0, 3'b111, 5, 1, 1, 0, 0, 0, 5);
      addv(0, 1, 0, 3'b101, 6, 1, 1, 0, 0, 0, 6);
      addv(0, 1, 0, 3'b100, 7, 1, 1, 0, 0, 0, 7);
      addv(0, 1, 0, 3'b000, 0, 1, 1, 0, 0, 0, 8);
      // down wrap of code and pos, then back up through both wraps
      addv(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b100, 7, 1, 0, 1, 0, 0, 255);
      addv(0, 1, 0, 3'b101, 6, 1, 0, 1, 0, 0, 254);
      addv(0, 1, 0, 3'b100, 7, 1, 1, 0, 0, 0, 255);
      addv(0, 1, 0, 3'b000, 0, 1, 1, 0, 0, 0, 0);
      // hold and gaps
      addv(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b010, 3, 1, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b010, 3, 1, 0, 0, 0, 0, 0);
      addv(0, 0, 0, 3'b111, 3, 0, 0, 0, 0, 0, 0);
      addv(0, 0, 0, 3'b100, 3, 0, 0, 0, 0, 0, 0);
      addv(0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 0);
      // illegal single-bit flip, fault suppression, clear and resync
      addv(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b001, 1, 1, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b101, 6, 1, 0, 0, 1, 1, 0);
      addv(0, 1, 0, 3'b111, 5, 1, 0, 0, 0, 1, 0);
      addv(0, 0, 0, 3'b111, 5, 0, 0, 0, 0, 1, 0);
      addv(0, 1, 1, 3'b000, 5, 0, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b110, 4, 1, 0, 0, 0, 0, 0);
      addv(0, 1, 0, 3'b111, 5, 1, 1, 0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], "table", i);
      end

      // climb to pos=5, then fault so sticky_err is set before the async reset
      step(3'b101, 6, 1, 1, 0, 0, 0, 2, "climb", 0);
      step(3'b100, 7, 1, 1, 0, 0, 0, 3, "climb", 1);
      step(3'b000, 0, 1, 1, 0, 0, 0, 4, "climb", 2);
      step(3'b001, 1, 1, 1, 0, 0, 0, 5, "climb", 3);
      step(3'b110, 4, 1, 0, 0, 1, 1, 5, "fault", 0);

      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      if (clk !== 1'b0) begin
         checks++; errors++;
         $display("FAIL async_window clk got %b want 0", clk);
      end
      compare("async_rst", 0, outs(0, 0, 0, 0, 0, 0, 0));

      // first sample after release resyncs without a step
      step(3'b011, 2, 1, 0, 0, 0, 0, 0, "post_rst", 0);
      step(3'b010, 3, 1, 1, 0, 0, 0, 1, "post_rst", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
